lcd_i80_rx: RTL
===============

Name: lcd_i80_rx

Overview:
- Upstream feeder for the 8080-to-RGB path.
- Samples an MCU 8080-style parallel write bus (CSn/WRn/DC/D[7:0]) asynchronous to CLK and decodes CASET/PASET/RAMWR commands.
- Streams RAMWR pixel bytes (RGB565, two bytes per pixel) into the display FIFO write port, which is clocked by CLK (100 MHz domain).
- Reports frame start/done and FIFO overflow to the rest of the design.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on all bus inputs (legal 2..4).
- H_RES, 480, default column window width.
- V_RES, 272, default row window height.
- CMD_CASET, 8'h2A, column-address-set command code.
- CMD_PASET, 8'h2B, page-address-set command code.
- CMD_RAMWR, 8'h2C, memory-write command code.

Ports:
- CLK  in  1  system clock; also the FIFO write clock.
- RST  in  1  asynchronous, active-high reset.
- I80_CSn  in  1  chip select, active low, async.
- I80_WRn  in  1  write strobe; data is captured on its rising edge; async.
- I80_DC  in  1  0 = command byte, 1 = data/parameter byte; async.
- I80_D  in  8  bus data; async.
- FIFO_FULL  in  1  display FIFO full flag.
- FIFO_WE  out  1  FIFO write enable, one cycle per byte.
- FIFO_DI  out  8  FIFO write data.
- FRAME_START  out  1  one-cycle pulse when a RAMWR command is accepted.
- FRAME_DONE  out  1  one-cycle pulse on the last byte of the window.
- OVERFLOW  out  1  sticky: at least one byte was dropped on FIFO_FULL.
- WIN_X0, WIN_X1, WIN_Y0, WIN_Y1  out  16 each  current window; inclusive bounds.

Behaviour:
- Reset values:
  - FIFO_WE, FRAME_START, FRAME_DONE, OVERFLOW = 0; FIFO_DI = 0.
  - WIN_X0 = 0, WIN_X1 = H_RES-1, WIN_Y0 = 0, WIN_Y1 = V_RES-1.
  - FSM = IDLE.
- Input synchronization:
  - All bus inputs pass through SYNC_STAGES flops.
  - A write event is a synchronized WRn 0->1 transition while synchronized CSn = 0.
  - D and DC are taken from the same synchronized stage as the WRn edge.
- Bus timing: the host must hold WRn low and high for at least SYNC_STAGES+1 CLK periods each. D/DC must be stable across the WRn rising edge.
- Command byte (DC = 0): always aborts the current state, then decodes.
  - CASET -> state CASET, parameter index cleared.
  - PASET -> state PASET, parameter index cleared.
  - RAMWR -> state RAMWR; pulses FRAME_START; clears byte/pixel counters and OVERFLOW.
  - Any other code -> IDLE; its parameters are ignored.
- CASET/PASET parameters (DC = 1):
  - 4 bytes, MSB first: start[15:8], start[7:0], end[15:8], end[7:0].
  - The window register updates atomically after the 4th byte; the FSM then returns to IDLE.
  - If aborted after fewer than 4 bytes, the window is unchanged.
- RAMWR data (DC = 1):
  - Each byte produces FIFO_WE = 1 with FIFO_DI = byte, SYNC_STAGES+1 cycles after the WRn pin rising edge.
  - Byte count target = 2*(X1-X0+1)*(Y1-Y0+1), computed with 32-bit unsigned arithmetic when RAMWR is accepted.
  - If X1 < X0 or Y1 < Y0, the target is treated as 2*H_RES*V_RES.
  - The write reaching the target pulses FRAME_DONE in the same cycle as its FIFO_WE; the counter then wraps to 0 and the FSM stays in RAMWR (continuous streaming).
- Data byte in IDLE: ignored.
- FIFO_FULL = 1 when a byte is due:
  - FIFO_WE stays 0 and the byte is dropped.
  - The byte counter still advances, so frame alignment is preserved.
  - OVERFLOW is set.
- CSn deasserted mid-sequence: state and counters are held; the sequence resumes on the next selected write.
- RST asserted mid-operation: immediate return to reset values; any partial byte is discarded.

Optional Feature:
- Macro: LCD_I80_BYTESWAP_EN.
- With macro: the first byte of each pixel is held and nothing is emitted for it. On the second byte, the FIFO receives the second byte and then the first byte on two consecutive cycles.
  - FIFO_FULL is checked per emitted byte.
  - FRAME_DONE aligns with the final emitted byte.
  - A command arriving between the two bytes discards the held byte.
- Without macro: bytes pass through in bus order, one FIFO_WE per write event.

Decomposition:
- Package lcd_i80_pkg: command code constants, FSM state enum {IDLE, CASET, PASET, RAMWR}, 16-bit coordinate typedef.
- Sub-module i80_sync: SYNC_STAGES synchronizer for {CSn, WRn, DC, D} plus WRn rising-edge detect. Outputs: write-event strobe, DC, D.

Test Plan:
- Reset, then RAMWR (0x2C) followed by 4 data bytes 0x11,0x22,0x33,0x44 -> FRAME_START once; FIFO_WE x4 with FIFO_DI 11,22,33,44; each FIFO_WE exactly SYNC_STAGES+1 cycles after its WRn rise.
- CASET 00 00 00 01, PASET 00 00 00 00, RAMWR, 4 bytes -> WIN_X0=0, WIN_X1=1, WIN_Y0=0, WIN_Y1=0; FRAME_DONE on the 4th byte; a 5th byte is written with counter restarted.
- CASET with 2 params, then RAMWR -> window unchanged (0..479); state is RAMWR.
- FIFO_FULL held high during bytes 2-3 of a 6-byte RAMWR -> FIFO_WE only for bytes 1, 4, 5, 6; OVERFLOW=1; a new RAMWR clears it.
- CSn high during WRn pulses with DC=1 -> no FIFO_WE; RST pulse mid-RAMWR -> outputs return to reset values and the next data byte is ignored (IDLE).
- With LCD_I80_BYTESWAP_EN: bytes 0xAB,0xCD -> FIFO_DI CD then AB on consecutive cycles.

Source files
------------

// File: rtl/lcd_i80_pkg.sv
// Shared types and command codes for the 8080-bus receiver.
package lcd_i80_pkg;

    typedef logic [15:0] coord_t;

    typedef enum logic [1:0] {
        IDLE,
        CASET,
        PASET,
        RAMWR
    } state_t;

    localparam logic [7:0] CMD_CASET_DEF = 8'h2A;
    localparam logic [7:0] CMD_PASET_DEF = 8'h2B;
    localparam logic [7:0] CMD_RAMWR_DEF = 8'h2C;

endpackage

// File: rtl/lcd_i80_rx_if.sv
// Bus bundle: MCU 8080 write bus in, display FIFO write port and status out.
interface lcd_i80_rx_if;

    logic                 I80_CSn;
    logic                 I80_WRn;
    logic                 I80_DC;
    logic [7:0]           I80_D;
    logic                 FIFO_FULL;
    logic                 FIFO_WE;
    logic [7:0]           FIFO_DI;
    logic                 FRAME_START;
    logic                 FRAME_DONE;
    logic                 OVERFLOW;
    lcd_i80_pkg::coord_t  WIN_X0;
    lcd_i80_pkg::coord_t  WIN_X1;
    lcd_i80_pkg::coord_t  WIN_Y0;
    lcd_i80_pkg::coord_t  WIN_Y1;

    modport master (
        output I80_CSn, I80_WRn, I80_DC, I80_D, FIFO_FULL,
        input  FIFO_WE, FIFO_DI, FRAME_START, FRAME_DONE, OVERFLOW,
        input  WIN_X0, WIN_X1, WIN_Y0, WIN_Y1
    );

    modport slave (
        input  I80_CSn, I80_WRn, I80_DC, I80_D, FIFO_FULL,
        output FIFO_WE, FIFO_DI, FRAME_START, FRAME_DONE, OVERFLOW,
        output WIN_X0, WIN_X1, WIN_Y0, WIN_Y1
    );

endinterface

// File: rtl/i80_sync.sv
// Synchronizes the asynchronous 8080 bus into CLK and flags selected WRn rising edges.
module i80_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic       dc,
    input  logic [7:0] d,
    output logic       wr_evt,
    output logic       dc_s,
    output logic [7:0] d_s
);

    // Packed as {cs_n, wr_n, dc, d}; reset to an idle, deselected bus.
    localparam logic [10:0] BUS_IDLE = 11'h600;

    logic [10:0] stg [SYNC_STAGES];
    logic        wr_prev;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < SYNC_STAGES; i++) stg[i] <= BUS_IDLE;
            wr_prev <= 1'b1;
        end else begin
            stg[0] <= {cs_n, wr_n, dc, d};
            for (int i = 1; i < SYNC_STAGES; i++) stg[i] <= stg[i-1];
            wr_prev <= stg[SYNC_STAGES-1][9];
        end
    end

    assign wr_evt = stg[SYNC_STAGES-1][9] & ~wr_prev & ~stg[SYNC_STAGES-1][10];
    assign dc_s   = stg[SYNC_STAGES-1][8];
    assign d_s    = stg[SYNC_STAGES-1][7:0];

endmodule

// File: rtl/lcd_i80_rx.sv
// 8080 write-bus receiver: decodes CASET/PASET/RAMWR and streams pixel bytes to the FIFO.
// Optional LCD_I80_BYTESWAP_EN swaps the two bytes of each RGB565 pixel.
//   state | meaning
//   IDLE  | no command active, data bytes ignored
//   CASET | collecting 4 column-window parameter bytes
//   PASET | collecting 4 row-window parameter bytes
//   RAMWR | streaming pixel bytes into the FIFO
module lcd_i80_rx
    import lcd_i80_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter int         H_RES       = 480,
    parameter int         V_RES       = 272,
    parameter logic [7:0] CMD_CASET   = CMD_CASET_DEF,
    parameter logic [7:0] CMD_PASET   = CMD_PASET_DEF,
    parameter logic [7:0] CMD_RAMWR   = CMD_RAMWR_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    lcd_i80_rx_if.slave bus
);

    localparam logic [31:0] FULL_FRAME = 32'(2 * H_RES * V_RES);

    logic        wr_evt;
    logic        dc_s;
    logic [7:0]  d_s;

    state_t      state;
    logic [1:0]  pidx;
    logic [7:0]  p0, p1, p2;
    coord_t      win_x0, win_x1, win_y0, win_y1;
    logic [31:0] cnt, target;
    logic [31:0] win_w, win_h, frame_target;
    logic        last_byte;
    logic        fifo_we, frame_start, frame_done, overflow;
    logic [7:0]  fifo_di;
`ifdef LCD_I80_BYTESWAP_EN
    logic        held_v, pend_v, pend_done;
    logic [7:0]  held_d;
`endif

    i80_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .CLK    (CLK),
        .RST    (RST),
        .cs_n   (bus.I80_CSn),
        .wr_n   (bus.I80_WRn),
        .dc     (bus.I80_DC),
        .d      (bus.I80_D),
        .wr_evt (wr_evt),
        .dc_s   (dc_s),
        .d_s    (d_s)
    );

    // An inverted window falls back to the full panel so streaming never stalls.
    assign win_w        = {16'd0, win_x1} - {16'd0, win_x0} + 32'd1;
    assign win_h        = {16'd0, win_y1} - {16'd0, win_y0} + 32'd1;
    assign frame_target = ((win_x1 < win_x0) || (win_y1 < win_y0)) ? FULL_FRAME
                                                                    : (win_w * win_h) << 1;
    assign last_byte    = (cnt + 32'd1) == target;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            pidx        <= '0;
            p0          <= '0;
            p1          <= '0;
            p2          <= '0;
            win_x0      <= '0;
            win_x1      <= coord_t'(H_RES - 1);
            win_y0      <= '0;
            win_y1      <= coord_t'(V_RES - 1);
            cnt         <= '0;
            target      <= '0;
            fifo_we     <= 1'b0;
            fifo_di     <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            overflow    <= 1'b0;
`ifdef LCD_I80_BYTESWAP_EN
            held_v      <= 1'b0;
            held_d      <= '0;
            pend_v      <= 1'b0;
            pend_done   <= 1'b0;
`endif
        end else begin
            fifo_we     <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
`ifdef LCD_I80_BYTESWAP_EN
            // Second emission of a swapped pixel: the first bus byte goes out last.
            if (pend_v) begin
                pend_v     <= 1'b0;
                frame_done <= pend_done;
                if (bus.FIFO_FULL) begin
                    overflow <= 1'b1;
                end else begin
                    fifo_we <= 1'b1;
                    fifo_di <= held_d;
                end
            end
`endif
            if (wr_evt) begin
                if (!dc_s) begin
                    pidx <= '0;
`ifdef LCD_I80_BYTESWAP_EN
                    held_v <= 1'b0;
`endif
                    case (d_s)
                        CMD_CASET: state <= CASET;
                        CMD_PASET: state <= PASET;
                        CMD_RAMWR: begin
                            state       <= RAMWR;
                            frame_start <= 1'b1;
                            cnt         <= '0;
                            overflow    <= 1'b0;
                            target      <= frame_target;
                        end
                        default:   state <= IDLE;
                    endcase
                end else begin
                    case (state)
                        CASET, PASET: begin
                            pidx <= pidx + 2'd1;
                            case (pidx)
                                2'd0:    p0 <= d_s;
                                2'd1:    p1 <= d_s;
                                2'd2:    p2 <= d_s;
                                default: begin
                                    if (state == CASET) begin
                                        win_x0 <= {p0, p1};
                                        win_x1 <= {p2, d_s};
                                    end else begin
                                        win_y0 <= {p0, p1};
                                        win_y1 <= {p2, d_s};
                                    end
                                    state <= IDLE;
                                end
                            endcase
                        end
                        RAMWR: begin
                            // Dropped bytes still count so frame alignment survives overflow.
                            cnt <= last_byte ? '0 : cnt + 32'd1;
`ifdef LCD_I80_BYTESWAP_EN
                            if (!held_v) begin
                                held_v <= 1'b1;
                                held_d <= d_s;
                            end else begin
                                held_v    <= 1'b0;
                                pend_v    <= 1'b1;
                                pend_done <= last_byte;
                                if (bus.FIFO_FULL) begin
                                    overflow <= 1'b1;
                                end else begin
                                    fifo_we <= 1'b1;
                                    fifo_di <= d_s;
                                end
                            end
`else
                            frame_done <= last_byte;
                            if (bus.FIFO_FULL) begin
                                overflow <= 1'b1;
                            end else begin
                                fifo_we <= 1'b1;
                                fifo_di <= d_s;
                            end
`endif
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.FIFO_WE     = fifo_we;
    assign bus.FIFO_DI     = fifo_di;
    assign bus.FRAME_START = frame_start;
    assign bus.FRAME_DONE  = frame_done;
    assign bus.OVERFLOW    = overflow;
    assign bus.WIN_X0      = win_x0;
    assign bus.WIN_X1      = win_x1;
    assign bus.WIN_Y0      = win_y0;
    assign bus.WIN_Y1      = win_y1;

endmodule
